// File: rtl/xoodoo_pkg.sv
`default_nettype none
// ============================================================================
// xoodoo_pkg : shared types and helpers for the Xoodoo permutation arbiter
// Rev 1.0
// ============================================================================
package xoodoo_pkg;

  localparam int STATE_W = 384;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Pointer width for a requester index; never narrower than one bit.
  function automatic int arb_ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xoodoo_rr_pick.sv
`default_nettype none
// ============================================================================
// xoodoo_rr_pick : combinational round-robin selector, first set req bit at or
//                  above rr_ptr, wrapping from NUM_REQ-1 back to 0
// Rev 1.0
// ============================================================================
module xoodoo_rr_pick
  import xoodoo_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [PTR_W-1:0]   idx
);

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[j]) begin
        valid = 1'b1;
        idx   = PTR_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/xoodoo_perm_arbiter.sv
`default_nettype none
// ============================================================================
// xoodoo_perm_arbiter : round-robin sharing of one Xoodoo permutation core
//                       among NUM_REQ sponge sequencers.
// Optional BUSY watchdog enabled by defining XOODOO_ARB_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
module xoodoo_perm_arbiter
  import xoodoo_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int STATE_W        = 384,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*STATE_W-1:0] req_state,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic [STATE_W-1:0]         resp_state,
  output logic                       err,
  output logic                       busy,
  output logic                       xoodoo_enable,
  output logic [STATE_W-1:0]         xoodoo_state_out,
  input  logic                       xoodoo_complete,
  input  logic [STATE_W-1:0]         xoodoo_state_in
);

  localparam int PTR_W = arb_ptr_w(NUM_REQ);

  arb_state_t       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] g_idx;
  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] next_ptr;

`ifdef XOODOO_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] counter;
`endif

  xoodoo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  assign next_ptr = (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      g_idx            <= '0;
      gnt              <= '0;
      done             <= '0;
      resp_state       <= '0;
      err              <= 1'b0;
      busy             <= 1'b0;
      xoodoo_enable    <= 1'b0;
      xoodoo_state_out <= '0;
`ifdef XOODOO_ARB_TIMEOUT_EN
      counter          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            g_idx            <= pick_idx;
            gnt              <= NUM_REQ'(1) << pick_idx;
            xoodoo_state_out <= req_state[pick_idx*STATE_W +: STATE_W];
            xoodoo_enable    <= 1'b1;
            busy             <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          xoodoo_enable <= 1'b0;
          state         <= BUSY;
`ifdef XOODOO_ARB_TIMEOUT_EN
          counter       <= '0;
`endif
        end
        BUSY: begin
          // A real completion takes priority over a watchdog expiry in the same cycle.
          if (xoodoo_complete) begin
            resp_state <= xoodoo_state_in;
            done       <= gnt;
            err        <= 1'b0;
            state      <= RESP;
          end
`ifdef XOODOO_ARB_TIMEOUT_EN
          else if (counter == CNT_LAST) begin
            resp_state <= xoodoo_state_out;
            done       <= gnt;
            err        <= 1'b1;
            state      <= RESP;
          end else begin
            counter <= counter + 1'b1;
          end
`endif
        end
        RESP: begin
          gnt    <= '0;
          done   <= '0;
          err    <= 1'b0;
          busy   <= 1'b0;
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xoodoo_perm_arbiter.sv
`default_nettype none
// ============================================================================
// tb_xoodoo_perm_arbiter : directed vector bench for xoodoo_perm_arbiter
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_xoodoo_perm_arbiter;

  localparam int N = 4;
  localparam int W = 384;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_state = '0;
  logic [N-1:0]   gnt, done;
  logic [W-1:0]   resp_state, xoodoo_state_out;
  logic           err, busy, xoodoo_enable;
  logic           xoodoo_complete = 1'b0;
  logic [W-1:0]   xoodoo_state_in = '0;

  xoodoo_perm_arbiter #(
    .NUM_REQ        (N),
    .STATE_W        (W),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .req              (req),
    .req_state        (req_state),
    .gnt              (gnt),
    .done             (done),
    .resp_state       (resp_state),
    .err              (err),
    .busy             (busy),
    .xoodoo_enable    (xoodoo_enable),
    .xoodoo_state_out (xoodoo_state_out),
    .xoodoo_complete  (xoodoo_complete),
    .xoodoo_state_in  (xoodoo_state_in)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [N-1:0] r;
    int           lat;
    logic [N-1:0] eg;
    int           ei;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pat(input int a);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = 32'h9E37_79B9 * 32'(a + 1) + 32'(k);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_states(input int tag);
    for (int i = 0; i < N; i++) req_state[i*W +: W] = pat(tag * 16 + i);
  endtask

  // One full operation: grant, enable pulse, core completes lat cycles after enable, done.
  task automatic run_op(input string nm, input logic [N-1:0] r, input int lat,
                        input logic [N-1:0] eg, input int ei, input int tag);
    logic [W-1:0] res;
    res = pat(1000 + tag);
    set_states(tag);
    req = r;
    xoodoo_state_in = res;
    tick();
    chk({nm, " gnt"},  W'(gnt), W'(eg));
    chk({nm, " en"},   W'(xoodoo_enable), W'(1));
    chk({nm, " busy"}, W'(busy), W'(1));
    chk({nm, " sout"}, xoodoo_state_out, pat(tag * 16 + ei));
    tick();
    chk({nm, " en_off"}, W'(xoodoo_enable), W'(0));
    repeat (lat - 1) tick();
    chk({nm, " early_done"}, W'(done), W'(0));
    xoodoo_complete = 1'b1;
    tick();
    xoodoo_complete = 1'b0;
    chk({nm, " done"}, W'(done), W'(eg));
    chk({nm, " resp"}, resp_state, res);
    chk({nm, " err"},  W'(err), W'(0));
    req = '0;
    tick();
    chk({nm, " idle"}, W'({busy, gnt, done}), W'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b0001, 12, 4'b0001, 0};
    tbl[1] = '{4'b0011,  3, 4'b0010, 1};
    tbl[2] = '{4'b0011,  5, 4'b0001, 0};
    tbl[3] = '{4'b0011,  2, 4'b0010, 1};
    tbl[4] = '{4'b0011,  4, 4'b0001, 0};
    tbl[5] = '{4'b0100,  3, 4'b0100, 2};
    tbl[6] = '{4'b1001,  3, 4'b1000, 3};
    tbl[7] = '{4'b1001,  3, 4'b0001, 0};

    repeat (2) tick();
    chk("rst outs", W'({gnt, done, err, busy, xoodoo_enable}), W'(0));
    chk("rst resp", resp_state, '0);
    chk("rst sout", xoodoo_state_out, '0);
    resetn = 1'b1;
    tick();

    for (int v = 0; v < 8; v++)
      run_op($sformatf("vec%0d", v), tbl[v].r, tbl[v].lat, tbl[v].eg, tbl[v].ei, v);

    // Stray completes in IDLE and ISSUE; req_state change and req drop during BUSY.
    xoodoo_complete = 1'b1;
    tick();
    xoodoo_complete = 1'b0;
    chk("stray idle", W'({busy, done}), W'(0));
    set_states(50);
    req = 4'b0010;
    xoodoo_state_in = pat(1050);
    tick();
    chk("stray gnt", W'(gnt), W'(4'b0010));
    xoodoo_complete = 1'b1;
    tick();
    xoodoo_complete = 1'b0;
    chk("stray issue", W'(done), W'(0));
    chk("stray busy", W'(busy), W'(1));
    req = '0;
    set_states(51);
    repeat (3) tick();
    chk("stray wait", W'(done), W'(0));
    xoodoo_complete = 1'b1;
    tick();
    xoodoo_complete = 1'b0;
    chk("stray done", W'(done), W'(4'b0010));
    chk("stray resp", resp_state, pat(1050));
    chk("stray sout", xoodoo_state_out, pat(50 * 16 + 1));
    tick();
    chk("stray idle2", W'(busy), W'(0));

    // Asynchronous reset while BUSY drops the op.
    set_states(60);
    req = 4'b0100;
    tick();
    chk("mid gnt", W'(gnt), W'(4'b0100));
    repeat (2) tick();
    resetn = 1'b0;
    #1;
    chk("mid rst outs", W'({gnt, done, busy, xoodoo_enable, err}), W'(0));
    chk("mid rst sout", xoodoo_state_out, '0);
    req = '0;
    tick();
    resetn = 1'b1;
    tick();
    chk("mid no done", W'(done), W'(0));
    run_op("after rst", 4'b0010, 3, 4'b0010, 1, 61);

`ifdef XOODOO_ARB_TIMEOUT_EN
    set_states(70);
    req = 4'b0001;
    xoodoo_state_in = pat(1070);
    tick();
    chk("to gnt", W'(gnt), W'(4'b0001));
    repeat (8) tick();
    chk("to early", W'(done), W'(0));
    tick();
    chk("to done", W'({done, err}), W'({4'b0001, 1'b1}));
    chk("to resp", resp_state, pat(70 * 16));
    req = '0;
    tick();
    chk("to idle", W'({busy, err}), W'(0));
    set_states(71);
    req = 4'b0001;
    xoodoo_state_in = pat(1071);
    tick();
    repeat (8) tick();
    xoodoo_complete = 1'b1;
    tick();
    xoodoo_complete = 1'b0;
    chk("to race done", W'({done, err}), W'({4'b0001, 1'b0}));
    chk("to race resp", resp_state, pat(1071));
    req = '0;
    tick();
`else
    run_op("long", 4'b0001, 40, 4'b0001, 0, 70);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
